// File: rtl/cpu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_fetch_pkg
// Brief   : Shared types and constants for the instruction-fetch controller.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_REQ   = 2'd1;
    localparam state_t S_VALID = 2'd2;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_latch.sv
`default_nettype none
// ============================================================================
// Module  : fetch_redirect_latch
// Brief   : Remembers a redirect that lands mid-request and flags misaligned
//           redirect targets.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_redirect_latch
    import cpu_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_active,
    input  logic        imem_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] eff_target,
    output logic        kill,
    output logic [31:0] pend_pc,
    output logic        misalign_err
);

    assign eff_target = align_word(redirect_target);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kill         <= 1'b0;
            pend_pc      <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            // A redirect without ack leaves the request running; the later
            // ack is dropped and the last pending target is used instead.
            if (req_active && imem_ack) begin
                kill <= 1'b0;
            end else if (req_active && redirect_valid) begin
                kill    <= 1'b1;
                pend_pc <= eff_target;
            end
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_ctrl
// Brief   : Owns the PC, sequences instruction-memory requests and hands
//           fetched words to decode, applying control-flow redirects.
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_err
);

    state_t      r_state;
    logic [31:0] r_pc;

    logic [31:0] w_eff_target;
    logic        w_kill;
    logic [31:0] w_pend_pc;
    logic [31:0] w_start_pc;
    logic [31:0] w_resume_pc;
    logic        w_req_active;

    assign w_req_active = (r_state == S_REQ);
    assign w_start_pc   = redirect_valid ? w_eff_target : r_pc;
    assign w_resume_pc  = redirect_valid ? w_eff_target : w_pend_pc;

    fetch_redirect_latch u_redirect (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_active      (w_req_active),
        .imem_ack        (imem_ack),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .eff_target      (w_eff_target),
        .kill            (w_kill),
        .pend_pc         (w_pend_pc),
        .misalign_err    (misalign_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= 32'd0;
            inst_valid <= 1'b0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pc      <= w_start_pc;
                    imem_req  <= 1'b1;
                    imem_addr <= w_start_pc;
                    r_state   <= S_REQ;
                end
                S_REQ: begin
                    // Address stays put mid-request; redirects are applied at ack.
                    if (imem_ack) begin
                        if (w_kill || redirect_valid) begin
                            r_pc      <= w_resume_pc;
                            imem_addr <= w_resume_pc;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= r_pc;
                            r_pc       <= r_pc + PC_STEP;
                            imem_req   <= 1'b0;
                            inst_valid <= 1'b1;
                            r_state    <= S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (redirect_valid || inst_ready) begin
                        r_pc       <= w_start_pc;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= w_start_pc;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_fetch_ctrl
// Brief   : Directed, table-driven self-checking bench for pc_fetch_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    pc_fetch_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_val, input logic [31:0] e_inst,
                           input logic [31:0] e_ipc, input logic e_err);
        chk({tag, " imem_req"},     {31'd0, imem_req},     {31'd0, e_req});
        chk({tag, " imem_addr"},    imem_addr,             e_addr);
        chk({tag, " inst_valid"},   {31'd0, inst_valid},   {31'd0, e_val});
        chk({tag, " inst"},         inst,                  e_inst);
        chk({tag, " inst_pc"},      inst_pc,               e_ipc);
        chk({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, e_err});
        chk({tag, " req_and_valid"}, {31'd0, imem_req & inst_valid}, 32'd0);
    endtask

    task automatic add(input logic rv, input logic [31:0] tgt, input logic ack,
                       input logic [31:0] rdata, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic e_val,
                       input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_err);
        vec_t v;
        v.rv = rv; v.tgt = tgt; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
        v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic [31:0] tgt, input logic ack,
                         input logic [31:0] rdata, input logic rdy);
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_ack        = ack;
        imem_rdata      = rdata;
        inst_ready      = rdy;
    endtask

    initial begin
        //  rv  target         ack rdata          rdy  req addr           val inst           inst_pc        err
        add(0, 32'h0,          1, 32'hA000_0000, 1,   1, 32'h0000_3000, 0, 32'h0,          32'h0,          0);
        add(0, 32'h0,          1, 32'hA000_0000, 1,   0, 32'h0000_3000, 1, 32'hA000_0000, 32'h0000_3000, 0);
        add(0, 32'h0,          1, 32'hA100_0000, 1,   1, 32'h0000_3004, 0, 32'hA000_0000, 32'h0000_3000, 0);
        add(0, 32'h0,          1, 32'hA100_0000, 1,   0, 32'h0000_3004, 1, 32'hA100_0000, 32'h0000_3004, 0);
        add(0, 32'h0,          0, 32'h0,         1,   1, 32'h0000_3008, 0, 32'hA100_0000, 32'h0000_3004, 0);
        add(0, 32'h0,          0, 32'h0,         0,   1, 32'h0000_3008, 0, 32'hA100_0000, 32'h0000_3004, 0);
        add(1, 32'h0000_3040,  0, 32'h0,         0,   1, 32'h0000_3008, 0, 32'hA100_0000, 32'h0000_3004, 0);
        add(0, 32'h0,          1, 32'hDEAD_BEEF, 0,   1, 32'h0000_3040, 0, 32'hA100_0000, 32'h0000_3004, 0);
        add(0, 32'h0,          0, 32'h0,         0,   1, 32'h0000_3040, 0, 32'hA100_0000, 32'h0000_3004, 0);
        add(0, 32'h0,          0, 32'h0,         0,   1, 32'h0000_3040, 0, 32'hA100_0000, 32'h0000_3004, 0);
        add(0, 32'h0,          1, 32'hB000_0000, 0,   0, 32'h0000_3040, 1, 32'hB000_0000, 32'h0000_3040, 0);
        for (int i = 0; i < 4; i++)
            add(0, 32'h0,      1, 32'hEEEE_EEEE, 0,   0, 32'h0000_3040, 1, 32'hB000_0000, 32'h0000_3040, 0);
        add(1, 32'h0000_3100,  0, 32'h0,         1,   1, 32'h0000_3100, 0, 32'hB000_0000, 32'h0000_3040, 0);
        add(0, 32'h0,          1, 32'hB100_0000, 0,   0, 32'h0000_3100, 1, 32'hB100_0000, 32'h0000_3100, 0);
        add(1, 32'h0000_3102,  0, 32'h0,         1,   1, 32'h0000_3100, 0, 32'hB100_0000, 32'h0000_3100, 1);
        add(0, 32'h0,          1, 32'hB200_0000, 0,   0, 32'h0000_3100, 1, 32'hB200_0000, 32'h0000_3100, 1);
        add(1, 32'hFFFF_FFFC,  0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'hB200_0000, 32'h0000_3100, 1);
        add(0, 32'h0,          1, 32'hB300_0000, 0,   0, 32'hFFFF_FFFC, 1, 32'hB300_0000, 32'hFFFF_FFFC, 1);
        add(0, 32'h0,          0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'hB300_0000, 32'hFFFF_FFFC, 1);
        add(0, 32'h0,          1, 32'hB400_0000, 0,   0, 32'h0000_0000, 1, 32'hB400_0000, 32'h0000_0000, 1);
        add(0, 32'h0,          0, 32'h0,         1,   1, 32'h0000_0004, 0, 32'hB400_0000, 32'h0000_0000, 1);
        add(1, 32'h0000_3200,  1, 32'hBAD0_BAD0, 0,   1, 32'h0000_3200, 0, 32'hB400_0000, 32'h0000_0000, 1);
        add(1, 32'h0000_3300,  0, 32'h0,         0,   1, 32'h0000_3200, 0, 32'hB400_0000, 32'h0000_0000, 1);
        add(1, 32'h0000_3400,  0, 32'h0,         0,   1, 32'h0000_3200, 0, 32'hB400_0000, 32'h0000_0000, 1);
        add(0, 32'h0,          1, 32'hC000_0000, 0,   1, 32'h0000_3400, 0, 32'hB400_0000, 32'h0000_0000, 1);
        add(0, 32'h0,          1, 32'hC100_0000, 0,   0, 32'h0000_3400, 1, 32'hC100_0000, 32'h0000_3400, 1);

        reset_n = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rv, vecs[i].tgt, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val,
                    vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_err);
        end

        // Reset dropped mid-request with an ack present must clear at once.
        drive(0, 32'h0, 0, 32'h0, 1);
        @(posedge clk);
        #1;
        chk_all("pre_reset_req", 1, 32'h0000_3404, 0, 32'hC100_0000, 32'h0000_3400, 1);
        drive(0, 32'h0, 1, 32'h1234_5678, 0);
        reset_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        chk_all("reset_ack_ignored", 0, 32'h0, 0, 32'h0, 32'h0, 0);

        // Three-cycle delayed ack at the reset PC.
        drive(0, 32'h0, 0, 32'h0, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("delay%0d", k), 1, 32'h0000_3000, 0, 32'h0, 32'h0, 0);
        end
        drive(0, 32'h0, 1, 32'hCAFE_0001, 0);
        @(posedge clk);
        #1;
        chk_all("delay_ack", 0, 32'h0000_3000, 1, 32'hCAFE_0001, 32'h0000_3000, 0);

        // Redirect during the idle cycle steers the very first request.
        reset_n = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1, 32'h0000_3500, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        chk_all("idle_redirect", 1, 32'h0000_3500, 0, 32'h0, 32'h0, 0);
        drive(0, 32'h0, 1, 32'hCAFE_0002, 0);
        @(posedge clk);
        #1;
        chk_all("idle_redirect_ack", 0, 32'h0000_3500, 1, 32'hCAFE_0002, 32'h0000_3500, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequences instruction fetch for the MIPS core. Owns the architectural PC register and issues word requests to instruction memory over a req/ack handshake. Presents each fetched instruction to decode over a valid/ready handshake. Applies redirects (taken branch, j/jal, jr) from the next-PC logic, and discards any fetch in flight when a redirect lands.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
redirect_valid  in  1  next-PC logic requests a control-flow change this cycle
redirect_target  in  32  new PC (branch/jump/jr result)
imem_req  out  1  fetch request, registered
imem_addr  out  32  fetch byte address, registered, stable while imem_req=1
imem_ack  in  1  memory returns data; sampled only while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
inst_valid  out  1  inst/inst_pc hold a live instruction
inst  out  32  fetched instruction
inst_pc  out  32  address of inst
inst_ready  in  1  decode accepts inst this cycle
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=S_IDLE. imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, misalign_err=0, kill=0, pend_pc=0.
- States: S_IDLE, S_REQ, S_VALID.
- S_IDLE: lasts exactly one cycle after reset release. Next state S_REQ, with imem_req=1 and imem_addr=pc.
- S_REQ: imem_req and imem_addr are held constant until imem_ack. Ack can arrive in the first request cycle, giving 1-cycle minimum latency.
  - Redirect, no ack: kill=1, pend_pc=target. Address is not changed mid-request.
  - Ack with kill=0 and no redirect: inst<=imem_rdata, inst_pc<=pc, pc<=pc+PC_STEP, imem_req<=0, go S_VALID.
  - Ack with kill=1 or a same-cycle redirect: drop the data. pc<=(redirect this cycle ? target : pend_pc). kill<=0. Reissue the request next cycle with the new address; stay in S_REQ.
- S_VALID: inst_valid=1. inst and inst_pc stay stable until accepted.
  - inst_ready=1: go S_REQ with imem_addr=pc. One bubble cycle between instructions is acceptable.
  - Redirect, with or without inst_ready: inst_valid<=0, pc<=target, go S_REQ with imem_addr=target. A same-cycle inst_ready still counts as a handshake for the current instruction.
- Redirect in S_IDLE: pc<=target. The first request uses the target.
- Multiple redirects before resolution: the last one wins.
- Misalignment: if redirect_target[1:0]!=0, the target is used with bits [1:0] forced to 0 and misalign_err<=1. misalign_err clears only on reset.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 -> 32'h0000_0000, with no error.
- inst_valid and imem_req are never both 1.
- Reset asserted mid-request: all state clears immediately. An ack arriving during reset is ignored.

Decomposition:
- Shared package cpu_fetch_pkg: state enum (S_IDLE, S_REQ, S_VALID), RESET_PC, PC_STEP, and the alignment-mask constant 32'hFFFF_FFFC.
- One natural sub-module, fetch_redirect_latch. It holds kill, pend_pc and misalign_err, and produces the aligned effective target.
- The FSM and PC register stay in the top level.

Test Plan:
- Reset release with ack tied high: imem_addr sequence is 0x3000, 0x3004, 0x3008. inst_pc matches each address. misalign_err=0.
- Delayed ack of 3 cycles at 0x3000: imem_req stays 1 and imem_addr stays 0x3000 for 3 cycles. inst=imem_rdata on the ack.
- Redirect to 0x3040 two cycles into a pending fetch of 0x3008: the 0x3008 data is dropped (inst_valid stays 0). The next request goes to 0x3040.
- inst_ready=0 for 4 cycles with inst_valid=1: inst and inst_pc are stable and no imem_req is issued. Then a redirect to 0x3100 in the same cycle as inst_ready=1: next request goes to 0x3100.
- Redirect target 0x3102: request goes to 0x3100 and misalign_err=1. It stays 1 until reset_n=0.
- Redirect to 0xFFFF_FFFC, then ack: the next request address is 0x0000_0000.
